// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared definitions for the peripheral bus router.
//   - state_e       : router FSM state encoding
//   - INT_CODE_NONE : interrupt code reported when no slave requests service
//   - RESP_OK/ERR   : values driven on io_err with a response
//   - idx_width()   : index width for an N-entry select (never below 1 bit)
package periph_bus_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StResp    = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam int unsigned INT_CODE_NONE = 0;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_addr_decoder.sv
// periph_addr_decoder: combinational base/mask match with lowest-index priority.
//   addr : address to decode
//   en   : per-slot enable; a disabled slot never hits
//   hit  : at least one enabled slot matched
//   idx  : lowest matching slot index (0 when no hit)
// Slot i matches when (addr & MASK[i]) == BASE[i]. With AW=1, BASE=0, MASK=all ones
// and addr=0 every slot matches, so the block degrades to a priority encoder of en.
module periph_addr_decoder
    import periph_bus_pkg::*;
#(
    parameter int unsigned     N    = 4,
    parameter int unsigned     AW   = 32,
    parameter logic [N*AW-1:0] BASE = '0,
    parameter logic [N*AW-1:0] MASK = '0
) (
    input  logic [AW-1:0]             addr,
    input  logic [N-1:0]              en,
    output logic                      hit,
    output logic [idx_width(N)-1:0]   idx
);

    localparam int unsigned IDX_W = idx_width(N);

    // Scan from the top down so the lowest matching slot is written last and wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en[i] && ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/periph_bus_router.sv
// periph_bus_router: single-master to N_SLV-slave peripheral bus router.
//   pclk, rst_n                 : clock, asynchronous active-low reset
//   io_addr/io_read/io_write/
//   io_wdata/io_byte_size       : CPU request, held until io_ready
//   io_rdata/io_ready/io_err    : registered one-cycle response
//   s_sel/s_read/s_write/s_addr/
//   s_wdata/s_byte_size         : latched request towards the selected slave
//   s_rdata/s_ready             : packed per-slave read data and completion
//   s_int                       : level interrupt requests
//   peripheral_int_code/int_valid : registered lowest-index interrupt code
module periph_bus_router
    import periph_bus_pkg::*;
#(
    parameter int unsigned              N_SLV    = 4,
    parameter int unsigned              ADDR_W   = 32,
    parameter int unsigned              DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]  SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]  SLV_MASK = '0,
    parameter int unsigned              TIMEOUT  = 255,
    parameter int unsigned              INT_W    = 5,
    parameter int unsigned              INT_BASE = 1
) (
    input  logic                        pclk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           io_addr,
    input  logic                        io_read,
    input  logic                        io_write,
    input  logic [DATA_W-1:0]           io_wdata,
    input  logic [1:0]                  io_byte_size,
    output logic [DATA_W-1:0]           io_rdata,
    output logic                        io_ready,
    output logic                        io_err,
    output logic [N_SLV-1:0]            s_sel,
    output logic                        s_read,
    output logic                        s_write,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [1:0]                  s_byte_size,
    input  logic [N_SLV*DATA_W-1:0]     s_rdata,
    input  logic [N_SLV-1:0]            s_ready,
    input  logic [N_SLV-1:0]            s_int,
    output logic [INT_W-1:0]            peripheral_int_code,
    output logic                        int_valid
);

    localparam int unsigned IDX_W = idx_width(N_SLV);
    // Wide enough to hold TIMEOUT itself.
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    state_e state_q, state_d;

    logic [N_SLV-1:0]  s_sel_q, s_sel_d;
    logic              s_read_q, s_read_d;
    logic              s_write_q, s_write_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [1:0]        s_byte_size_q, s_byte_size_d;
    logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              io_ready_q, io_ready_d;
    logic              io_err_q, io_err_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic [INT_W-1:0]  int_code_q, int_code_d;
    logic              int_valid_q, int_valid_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              int_hit;
    logic [IDX_W-1:0]  int_idx;

    logic              req;
    logic              req_legal;
    logic              accept_hit, accept_miss, slv_done, slv_tout;
    logic [DATA_W-1:0] sel_rdata;

    assign req       = io_read | io_write;
    // Simultaneous read and write is not a legal request; it is answered as a miss.
    assign req_legal = io_read ^ io_write;
    assign sel_rdata = s_rdata[sel_idx_q*DATA_W +: DATA_W];

    periph_addr_decoder #(
        .N    (N_SLV),
        .AW   (ADDR_W),
        .BASE (SLV_BASE),
        .MASK (SLV_MASK)
    ) u_addr_dec (
        .addr (io_addr),
        .en   ({N_SLV{1'b1}}),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Every slot matches a zero address, so this is a lowest-set-bit encoder of s_int.
    periph_addr_decoder #(
        .N    (N_SLV),
        .AW   (1),
        .BASE ({N_SLV{1'b0}}),
        .MASK ({N_SLV{1'b1}})
    ) u_int_enc (
        .addr (1'b0),
        .en   (s_int),
        .hit  (int_hit),
        .idx  (int_idx)
    );

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        slv_done    = 1'b0;
        slv_tout    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_legal && dec_hit) begin
                        accept_hit = 1'b1;
                        state_d    = StAccess;
                    end else begin
                        accept_miss = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            StAccess: begin
                // Only the selected slave can complete; a ready on the last counted
                // cycle still beats the timeout.
                if (s_ready[sel_idx_q]) begin
                    slv_done = 1'b1;
                    state_d  = StResp;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                    slv_tout = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        s_sel_d       = s_sel_q;
        s_read_d      = s_read_q;
        s_write_d     = s_write_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_byte_size_d = s_byte_size_q;
        sel_idx_d     = sel_idx_q;
        io_rdata_d    = io_rdata_q;
        io_ready_d    = 1'b0;
        io_err_d      = 1'b0;
        cnt_d         = '0;

        if ((state_q == StAccess) && (state_d == StAccess) && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept_hit || accept_miss) begin
            s_addr_d      = io_addr;
            s_wdata_d     = io_wdata;
            s_byte_size_d = io_byte_size;
            sel_idx_d     = dec_idx;
        end

        if (accept_hit) begin
            s_sel_d   = N_SLV'(1) << dec_idx;
            s_read_d  = io_read;
            s_write_d = io_write;
        end

        if (accept_miss) begin
            io_ready_d = 1'b1;
            io_err_d   = RESP_ERR;
            io_rdata_d = '0;
        end

        if (slv_done || slv_tout) begin
            io_ready_d = 1'b1;
            io_err_d   = slv_done ? RESP_OK : RESP_ERR;
            io_rdata_d = (slv_done && s_read_q) ? sel_rdata : '0;
            s_sel_d    = '0;
            s_read_d   = 1'b0;
            s_write_d  = 1'b0;
        end

        int_code_d  = int_hit ? (INT_W'(INT_BASE) + INT_W'(int_idx)) : INT_W'(INT_CODE_NONE);
        int_valid_d = |s_int;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s_sel_q       <= '0;
            s_read_q      <= 1'b0;
            s_write_q     <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_byte_size_q <= '0;
            sel_idx_q     <= '0;
            cnt_q         <= '0;
            io_ready_q    <= 1'b0;
            io_err_q      <= 1'b0;
            io_rdata_q    <= '0;
            int_code_q    <= '0;
            int_valid_q   <= 1'b0;
        end else begin
            s_sel_q       <= s_sel_d;
            s_read_q      <= s_read_d;
            s_write_q     <= s_write_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_byte_size_q <= s_byte_size_d;
            sel_idx_q     <= sel_idx_d;
            cnt_q         <= cnt_d;
            io_ready_q    <= io_ready_d;
            io_err_q      <= io_err_d;
            io_rdata_q    <= io_rdata_d;
            int_code_q    <= int_code_d;
            int_valid_q   <= int_valid_d;
        end
    end

    assign s_sel               = s_sel_q;
    assign s_read              = s_read_q;
    assign s_write             = s_write_q;
    assign s_addr              = s_addr_q;
    assign s_wdata             = s_wdata_q;
    assign s_byte_size         = s_byte_size_q;
    assign io_ready            = io_ready_q;
    assign io_err              = io_err_q;
    assign io_rdata            = io_rdata_q;
    assign peripheral_int_code = int_code_q;
    assign int_valid           = int_valid_q;

endmodule
